// File: rtl/spike_or_merger.sv
// rtl/spike_or_merger.sv - merges N_CH up/down spike channels into one fixed-width pulse with dead-time and counters
//
// Purpose:
//   Synchronises N_CH asynchronous UP/DOWN spike lines and detects their rising edges.
//   Enabled edges are merged into a single PULSE_W-clock CH_OUT pulse that carries
//   direction flags. A DEADTIME lockout follows each pulse, and saturating counters
//   track accepted up/down events and events dropped while busy.
//
// Ports:
//   CLK       system clock (single domain)
//   RST_N     synchronous active-low reset
//   UP        [N_CH] asynchronous up-spike lines
//   DOWN      [N_CH] asynchronous down-spike lines
//   CH_EN     [N_CH] per-channel enable mask
//   CLR_CNT   synchronous clear of all three counters
//   CH_OUT    merged spike pulse
//   CH_UP     up-direction flag, valid while CH_OUT=1
//   CH_DOWN   down-direction flag, valid while CH_OUT=1
//   UP_CNT    [CNT_W] accepted up events
//   DOWN_CNT  [CNT_W] accepted down events
//   DROP_CNT  [CNT_W] cycles with events rejected during PULSE/HOLD
//   BUSY      high while in PULSE or HOLD

module spike_or_merger #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_W     = 10,
    parameter int DEADTIME    = 20,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_CH-1:0]  UP,
    input  logic [N_CH-1:0]  DOWN,
    input  logic [N_CH-1:0]  CH_EN,
    input  logic             CLR_CNT,
    output logic             CH_OUT,
    output logic             CH_UP,
    output logic             CH_DOWN,
    output logic [CNT_W-1:0] UP_CNT,
    output logic [CNT_W-1:0] DOWN_CNT,
    output logic [CNT_W-1:0] DROP_CNT,
    output logic             BUSY
);

    // The shared timer counts down from PULSE_W-1 or DEADTIME-1, so it only needs
    // to hold values up to the larger of the two minus one.
    localparam int CMAX = (PULSE_W > DEADTIME) ? PULSE_W : DEADTIME;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int DT_LOAD_I = (DEADTIME > 0) ? DEADTIME - 1 : 0;
    localparam logic [CW-1:0] PW_LOAD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] DT_LOAD = CW'(DT_LOAD_I);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and edge history
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][N_CH-1:0] up_sync_q;
    logic [SYNC_STAGES-1:0][N_CH-1:0] dn_sync_q;
    logic [N_CH-1:0]                  up_prev_q;
    logic [N_CH-1:0]                  dn_prev_q;
    logic                             up_ev_q;
    logic                             dn_ev_q;

    logic [N_CH-1:0] up_rise;
    logic [N_CH-1:0] dn_rise;

    assign up_rise = up_sync_q[SYNC_STAGES-1] & ~up_prev_q & CH_EN;
    assign dn_rise = dn_sync_q[SYNC_STAGES-1] & ~dn_prev_q & CH_EN;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            up_sync_q <= '0;
            dn_sync_q <= '0;
            up_prev_q <= '0;
            dn_prev_q <= '0;
            up_ev_q   <= 1'b0;
            dn_ev_q   <= 1'b0;
        end else begin
            up_sync_q[0] <= UP;
            dn_sync_q[0] <= DOWN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                up_sync_q[i] <= up_sync_q[i-1];
                dn_sync_q[i] <= dn_sync_q[i-1];
            end
            up_prev_q <= up_sync_q[SYNC_STAGES-1];
            dn_prev_q <= dn_sync_q[SYNC_STAGES-1];
            // Merged events are registered so the FSM sees a clean flop output;
            // this stage sets the SYNC_STAGES+1 input-to-CH_OUT latency.
            up_ev_q   <= |up_rise;
            dn_ev_q   <= |dn_rise;
        end
    end

    logic any_ev;
    assign any_ev = up_ev_q | dn_ev_q;

    // ------------------------------------------------------------------
    // Pulse / dead-time FSM
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [CW-1:0]   tmr_q;
    logic            ch_out_q;
    logic            ch_up_q;
    logic            ch_dn_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            ch_out_q <= 1'b0;
            ch_up_q  <= 1'b0;
            ch_dn_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_ev) begin
                        state_q  <= S_PULSE;
                        tmr_q    <= PW_LOAD;
                        ch_out_q <= 1'b1;
                        ch_up_q  <= up_ev_q;
                        ch_dn_q  <= dn_ev_q;
                    end
                end
                S_PULSE: begin
                    if (tmr_q == '0) begin
                        ch_out_q <= 1'b0;
                        ch_up_q  <= 1'b0;
                        ch_dn_q  <= 1'b0;
                        tmr_q    <= DT_LOAD;
                        state_q  <= (DEADTIME > 0) ? S_HOLD : S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (tmr_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    tmr_q    <= '0;
                    ch_out_q <= 1'b0;
                    ch_up_q  <= 1'b0;
                    ch_dn_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating counters
    // ------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    logic             accept;
    logic             drop;
    logic [CNT_W-1:0] up_cnt_q,   up_cnt_d;
    logic [CNT_W-1:0] dn_cnt_q,   dn_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign accept = (state_q == S_IDLE) && any_ev;
    // One drop per cycle regardless of how many channels fired.
    assign drop   = (state_q != S_IDLE) && any_ev;

    always_comb begin
        up_cnt_d   = sat_inc(up_cnt_q, accept & up_ev_q);
        dn_cnt_d   = sat_inc(dn_cnt_q, accept & dn_ev_q);
        drop_cnt_d = sat_inc(drop_cnt_q, drop);
        if (CLR_CNT) begin
            up_cnt_d   = '0;
            dn_cnt_d   = '0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            up_cnt_q   <= '0;
            dn_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            up_cnt_q   <= up_cnt_d;
            dn_cnt_q   <= dn_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign CH_OUT   = ch_out_q;
    assign CH_UP    = ch_up_q;
    assign CH_DOWN  = ch_dn_q;
    assign UP_CNT   = up_cnt_q;
    assign DOWN_CNT = dn_cnt_q;
    assign DROP_CNT = drop_cnt_q;
    assign BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_spike_or_merger.sv
// tb/tb_spike_or_merger.sv - directed self-checking bench for spike_or_merger

module tb_spike_or_merger;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  up, down, ch_en;
    logic        clr;
    logic        ch_out, ch_up, ch_down, busy;
    logic [15:0] up_cnt, down_cnt, drop_cnt;

    logic [3:0]  s_up, s_down, s_ch_en;
    logic        s_clr;
    logic        s_ch_out, s_ch_up, s_ch_down, s_busy;
    logic [3:0]  s_up_cnt, s_down_cnt, s_drop_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_cnt    = 0;
    logic out_prev   = 1'b0;

    always #5 clk = ~clk;

    spike_or_merger dut (
        .CLK(clk), .RST_N(rst_n), .UP(up), .DOWN(down), .CH_EN(ch_en),
        .CLR_CNT(clr), .CH_OUT(ch_out), .CH_UP(ch_up), .CH_DOWN(ch_down),
        .UP_CNT(up_cnt), .DOWN_CNT(down_cnt), .DROP_CNT(drop_cnt), .BUSY(busy)
    );

    spike_or_merger #(.CNT_W(4)) dut_sat (
        .CLK(clk), .RST_N(rst_n), .UP(s_up), .DOWN(s_down), .CH_EN(s_ch_en),
        .CLR_CNT(s_clr), .CH_OUT(s_ch_out), .CH_UP(s_ch_up), .CH_DOWN(s_ch_down),
        .UP_CNT(s_up_cnt), .DOWN_CNT(s_down_cnt), .DROP_CNT(s_drop_cnt), .BUSY(s_busy)
    );

    // Advance one clock and sample 1ns after the edge; counts CH_OUT rising edges.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ch_out && !out_prev) pulse_cnt++;
        out_prev = ch_out;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(1);
        pulse_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        up    = 4'hF;
        ticks(5);
        tests_run++;
        if ({ch_out, ch_up, ch_down, busy, up_cnt, down_cnt, drop_cnt} !== 52'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got out=%b up=%b dn=%b busy=%b cnts=%0d/%0d/%0d, want all 0",
                     ch_out, ch_up, ch_down, busy, up_cnt, down_cnt, drop_cnt);
        end
        up    = 4'h0;
        rst_n = 1'b1;
        ticks(10);
        tests_run++;
        if ({ch_out, busy, up_cnt, down_cnt, drop_cnt} !== 50'd0) begin
            tests_failed++;
            $display("FAIL idle_after_release: got out=%b busy=%b cnts=%0d/%0d/%0d, want all 0",
                     ch_out, busy, up_cnt, down_cnt, drop_cnt);
        end
    endtask

    task automatic test_single_up();
        int first_hi, hi_cnt, busy_cnt, flag_bad;
        do_reset();
        first_hi = -1; hi_cnt = 0; busy_cnt = 0; flag_bad = 0;
        up[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 9) up[0] = 1'b0;
            if (ch_out) begin
                if (first_hi < 0) first_hi = i;
                hi_cnt++;
                if (ch_up !== 1'b1 || ch_down !== 1'b0) flag_bad++;
            end
            if (busy) busy_cnt++;
        end
        tests_run++;
        if (first_hi != 3) begin
            tests_failed++;
            $display("FAIL single_latency: first CH_OUT after edge %0d, want 3", first_hi);
        end
        tests_run++;
        if (hi_cnt != 10) begin
            tests_failed++;
            $display("FAIL single_width: CH_OUT high %0d clocks, want 10", hi_cnt);
        end
        tests_run++;
        if (flag_bad != 0) begin
            tests_failed++;
            $display("FAIL single_flags: %0d cycles with wrong CH_UP/CH_DOWN, want 0", flag_bad);
        end
        tests_run++;
        if (busy_cnt != 30) begin
            tests_failed++;
            $display("FAIL single_busy: BUSY high %0d clocks, want 30", busy_cnt);
        end
        tests_run++;
        if (up_cnt !== 16'd1 || down_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL single_counts: up=%0d dn=%0d drop=%0d, want 1/0/0", up_cnt, down_cnt, drop_cnt);
        end
    endtask

    task automatic run_train(input logic is_down);
        for (int k = 0; k < 10; k++) begin
            if (is_down) down[0] = 1'b1; else up[0] = 1'b1;
            ticks(2);
            down[0] = 1'b0; up[0] = 1'b0;
            ticks(8);
            if (is_down) down[1] = 1'b1; else up[1] = 1'b1;
            ticks(2);
            down[1] = 1'b0; up[1] = 1'b0;
            ticks(121);
        end
    endtask

    task automatic test_train();
        do_reset();
        run_train(1'b0);
        tests_run++;
        if (up_cnt !== 16'd10 || drop_cnt !== 16'd10 || down_cnt !== 16'd0 || pulse_cnt != 10) begin
            tests_failed++;
            $display("FAIL up_train: up=%0d drop=%0d dn=%0d pulses=%0d, want 10/10/0/10",
                     up_cnt, drop_cnt, down_cnt, pulse_cnt);
        end
        run_train(1'b1);
        tests_run++;
        if (down_cnt !== 16'd10 || drop_cnt !== 16'd20 || up_cnt !== 16'd10 || pulse_cnt != 20) begin
            tests_failed++;
            $display("FAIL down_train: dn=%0d drop=%0d up=%0d pulses=%0d, want 10/20/10/20",
                     down_cnt, drop_cnt, up_cnt, pulse_cnt);
        end
    endtask

    task automatic test_simultaneous_mask();
        int both_seen, busy_seen;
        do_reset();
        ch_en = 4'b1111;
        both_seen = 0;
        up[2] = 1'b1; down[3] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ch_out && ch_up && ch_down) both_seen++;
        end
        up[2] = 1'b0; down[3] = 1'b0;
        ticks(5);
        tests_run++;
        if (both_seen != 10 || pulse_cnt != 1) begin
            tests_failed++;
            $display("FAIL simul_pulse: both-flag cycles=%0d pulses=%0d, want 10/1", both_seen, pulse_cnt);
        end
        tests_run++;
        if (up_cnt !== 16'd1 || down_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL simul_counts: up=%0d dn=%0d drop=%0d, want 1/1/0", up_cnt, down_cnt, drop_cnt);
        end
        ch_en = 4'b0011;
        busy_seen = 0;
        up[2] = 1'b1; down[3] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy || ch_out) busy_seen++;
        end
        up[2] = 1'b0; down[3] = 1'b0;
        ch_en = 4'b1111;
        tests_run++;
        if (busy_seen != 0 || pulse_cnt != 1 || up_cnt !== 16'd1 || down_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL masked: busy_cycles=%0d pulses=%0d up=%0d dn=%0d drop=%0d, want 0/1/1/1/0",
                     busy_seen, pulse_cnt, up_cnt, down_cnt, drop_cnt);
        end
    endtask

    task automatic sat_spike();
        s_up[0] = 1'b1;
        ticks(2);
        s_up[0] = 1'b0;
        ticks(38);
    endtask

    task automatic test_saturation_clear();
        do_reset();
        for (int k = 0; k < 14; k++) sat_spike();
        tests_run++;
        if (s_up_cnt !== 4'd14) begin
            tests_failed++;
            $display("FAIL sat_before: UP_CNT=%0d, want 14", s_up_cnt);
        end
        for (int k = 0; k < 6; k++) sat_spike();
        tests_run++;
        if (s_up_cnt !== 4'd15 || s_drop_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL sat_hold: UP_CNT=%0d DROP_CNT=%0d, want 15/0", s_up_cnt, s_drop_cnt);
        end
        // Rise sampled at relative edge 0; the FSM accepts at edge 3, where CLR_CNT lands.
        s_up[0] = 1'b1;
        ticks(3);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        s_up[0] = 1'b0;
        tests_run++;
        if (s_up_cnt !== 4'd0 || s_ch_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_priority: UP_CNT=%0d CH_OUT=%b, want 0/1", s_up_cnt, s_ch_out);
        end
        ticks(36);
        sat_spike();
        tests_run++;
        if (s_up_cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL after_clear: UP_CNT=%0d, want 1", s_up_cnt);
        end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        up[0] = 1'b1;
        ticks(7);
        tests_run++;
        if (ch_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pulse_active: CH_OUT=%b, want 1", ch_out);
        end
        rst_n = 1'b0;
        up[0] = 1'b0;
        tick();
        tests_run++;
        if (ch_out !== 1'b0 || busy !== 1'b0 || up_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_pulse_abort: CH_OUT=%b BUSY=%b UP_CNT=%0d, want 0/0/0", ch_out, busy, up_cnt);
        end
        rst_n = 1'b1;
        up[0] = 1'b1;
        ticks(4);
        tests_run++;
        if (ch_out !== 1'b1 || up_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL after_reset_spike: CH_OUT=%b UP_CNT=%0d, want 1/1", ch_out, up_cnt);
        end
        up[0] = 1'b0;
        ticks(40);
    endtask

    initial begin
        rst_n = 1'b0;
        up = '0; down = '0; ch_en = 4'b1111; clr = 1'b0;
        s_up = '0; s_down = '0; s_ch_en = 4'b1111; s_clr = 1'b0;
        test_reset();
        test_single_up();
        test_train();
        test_simultaneous_mask();
        test_saturation_clear();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spike_or_merger.md
Name: spike_or_merger

Overview:
- Parametrised successor to the two-channel up/down spike OR.
- Merges N_CH asynchronous spike channels, each with UP and DOWN lines, into one fixed-width output pulse plus direction flags.
- Adds synchronisation, rising-edge detection, per-channel enable masking, dead-time lockout and saturating event/drop counters.
- Sits between the spike front-end inputs and downstream channel-output logic.

Parameters:
N_CH, 4, number of input channels (1..16)
SYNC_STAGES, 2, synchroniser flops per input line (>=2)
PULSE_W, 10, CH_OUT high time in clocks (>=1)
DEADTIME, 20, lockout clocks after a pulse ends (>=0)
CNT_W, 16, counter width

Ports:
CLK  in  1  system clock; one clock domain
RST_N  in  1  reset, synchronous, active-low
UP  in  N_CH  asynchronous up-spike lines, one per channel
DOWN  in  N_CH  asynchronous down-spike lines, one per channel
CH_EN  in  N_CH  channel enable mask; sampled each clock
CLR_CNT  in  1  synchronous counter clear
CH_OUT  out  1  merged spike pulse
CH_UP  out  1  direction flag, valid while CH_OUT=1
CH_DOWN  out  1  direction flag, valid while CH_OUT=1
UP_CNT  out  CNT_W  accepted up events
DOWN_CNT  out  CNT_W  accepted down events
DROP_CNT  out  CNT_W  events rejected during PULSE/DEADTIME
BUSY  out  1  high in PULSE or HOLD

Behaviour:
- Reset: on a CLK edge with RST_N=0, the following clear to 0: all outputs, synchroniser flops, edge-history flops and counters. The FSM goes to IDLE.
- Reset mid-pulse aborts the pulse immediately; there is no residual HOLD.
- Input path: each UP/DOWN bit passes through a SYNC_STAGES flop chain.
- Edge detect: an event occurs when the synchronised bit is 1 and its previous value is 0. Levels held high produce one event.
- Enable mask: an event counts only if its CH_EN bit is 1. Masked events are ignored entirely and are not counted as drops.
- Definitions: up_ev = OR of enabled up edges; dn_ev = OR of enabled down edges; any_ev = up_ev | dn_ev.
- Latency: an input first sampled high at edge 0 gives CH_OUT=1 after edge SYNC_STAGES+1 (3 clocks by default).
- FSM IDLE:
  - any_ev -> PULSE.
  - Load pulse counter with PULSE_W-1.
  - CH_OUT=1; CH_UP=up_ev; CH_DOWN=dn_ev.
  - UP_CNT += up_ev; DOWN_CNT += dn_ev.
- FSM PULSE:
  - CH_OUT held 1 for exactly PULSE_W clocks; direction flags are held constant.
  - At the last cycle: go to HOLD if DEADTIME>0, else IDLE. CH_OUT, CH_UP and CH_DOWN go to 0.
- FSM HOLD: counts DEADTIME clocks, then -> IDLE. A new event can start a pulse on the first IDLE cycle.
- Drops: any_ev while in PULSE or HOLD increments DROP_CNT by 1 per cycle, regardless of how many channels fired. There is no retrigger or pulse extension.
- Simultaneous events:
  - Up and down events in the same cycle set both CH_UP and CH_DOWN, and increment both UP_CNT and DOWN_CNT by 1.
  - Multiple channels firing in the same cycle merge into one pulse and one count per direction.
- Counters:
  - Saturate at 2^CNT_W-1 with no wrap.
  - CLR_CNT=1 zeroes all three counters on that edge.
  - CLR_CNT has priority over a same-cycle increment. The FSM is unaffected by CLR_CNT.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset/idle: hold RST_N=0 for 5 clocks with UP=4'hF -> all outputs 0. Release with inputs 0 -> outputs stay 0 and BUSY=0.
- Single up spike: UP[0] high for 10 clocks (defaults) -> CH_OUT high for exactly 10 clocks starting 3 edges after sampling; CH_UP=1, CH_DOWN=0, UP_CNT=1, BUSY high for 30 clocks.
- Alternating A/B train: UP[0] pulse, then UP[1] pulse 10 clocks later (inside PULSE), repeated 10 times with 123-clock gaps -> UP_CNT=10, DROP_CNT=10, 10 CH_OUT pulses. Repeat the train on DOWN -> DOWN_CNT=10, DROP_CNT=20.
- Simultaneous/mask: UP[2] and DOWN[3] rising in the same clock with CH_EN=4'b1111 -> one pulse, CH_UP=CH_DOWN=1, both counts +1. Same stimulus with CH_EN=4'b0011 -> no pulse, no count change, DROP_CNT unchanged.
- Saturation/clear: CNT_W=4, 20 spaced up spikes -> UP_CNT=15. Assert CLR_CNT in the same cycle as an accepted event -> UP_CNT=0.
- Reset mid-pulse: drop RST_N on the 4th CH_OUT cycle -> CH_OUT=0 next edge. A spike immediately after release is accepted with no dead-time.
